// File: rtl/time_keeper_if.sv
// Bundle between the mode controller and the timekeeping datapath:
// field-select/adjust controls in, current time, alarm and match status out.
interface time_keeper_if;
    logic [4:0] EN;
    logic       adjust;
    logic       up;
    logic       down;
    logic [4:0] time_h;
    logic [5:0] time_m;
    logic [5:0] time_s;
    logic [4:0] alarm_h;
    logic [5:0] alarm_m;
    logic       armed;
    logic       Z;
    logic       tick;

    modport master (
        output EN, adjust, up, down,
        input  time_h, time_m, time_s, alarm_h, alarm_m, armed, Z, tick
    );

    modport slave (
        input  EN, adjust, up, down,
        output time_h, time_m, time_s, alarm_h, alarm_m, armed, Z, tick
    );
endinterface

// File: rtl/time_keeper.sv
// 24-hour time/alarm datapath: per-second prescaler, non-carrying field adjust, registered alarm match.
// Optional macro ADJ_SEC_CLR_EN: a time-hours/minutes adjust also zeroes seconds and the prescaler.
module time_keeper #(
    parameter int unsigned TICK_DIV = 100_000_000
) (
    input  logic         clk,
    input  logic         rst,
    time_keeper_if.slave bus
);
    localparam int unsigned   PW     = $clog2(TICK_DIV);
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_TIME_H,
        SEL_TIME_M,
        SEL_ALARM_H,
        SEL_ALARM_M
    } sel_e;

    logic [PW-1:0] r_presc;
    logic [4:0]    r_h;
    logic [5:0]    r_m;
    logic [5:0]    r_s;
    logic [4:0]    r_ah;
    logic [5:0]    r_am;
    logic          r_armed;
    logic          r_z;
    logic          r_tick;

    sel_e          w_sel;
    logic          w_step;
    logic          w_dn;
    logic          w_wrap;
    logic          w_time_adj;
    logic [4:0]    w_h_adj;
    logic [5:0]    w_m_adj;
    logic [4:0]    w_ah_adj;
    logic [5:0]    w_am_adj;
    logic [5:0]    w_s_tick;
    logic [5:0]    w_m_tick;
    logic [4:0]    w_h_tick;

    function automatic logic [5:0] wrap_step(input logic [5:0] v, input logic [5:0] top,
                                             input logic dn);
        if (dn)
            return (v == '0) ? top : v - 6'd1;
        return (v == top) ? '0 : v + 6'd1;
    endfunction

    assign w_step = bus.adjust & (bus.up ^ bus.down);
    assign w_dn   = bus.down;

    always_comb begin
        w_sel = SEL_NONE;
        if (w_step) begin
            if (bus.EN[4])
                w_sel = SEL_TIME_H;
            else if (bus.EN[3])
                w_sel = SEL_TIME_M;
            else if (bus.EN[2])
                w_sel = SEL_ALARM_H;
            else if (bus.EN[1])
                w_sel = SEL_ALARM_M;
        end
    end

    assign w_wrap     = bus.EN[0] & (r_presc == P_LAST);
    assign w_time_adj = (w_sel == SEL_TIME_H) | (w_sel == SEL_TIME_M);

    assign w_h_adj  = 5'(wrap_step({1'b0, r_h}, 6'd23, w_dn));
    assign w_m_adj  = wrap_step(r_m, 6'd59, w_dn);
    assign w_ah_adj = 5'(wrap_step({1'b0, r_ah}, 6'd23, w_dn));
    assign w_am_adj = wrap_step(r_am, 6'd59, w_dn);

    // Second tick carry chain; only consulted when no time-field adjust wins the cycle.
    assign w_s_tick = wrap_step(r_s, 6'd59, 1'b0);
    assign w_m_tick = (r_s == 6'd59) ? wrap_step(r_m, 6'd59, 1'b0) : r_m;
    assign w_h_tick = ((r_s == 6'd59) && (r_m == 6'd59)) ?
                      5'(wrap_step({1'b0, r_h}, 6'd23, 1'b0)) : r_h;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_presc <= '0;
            r_h     <= '0;
            r_m     <= '0;
            r_s     <= '0;
            r_ah    <= '0;
            r_am    <= '0;
            r_armed <= 1'b0;
            r_z     <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            r_z    <= r_armed & (r_h == r_ah) & (r_m == r_am);

            if (w_wrap)
                r_presc <= '0;
            else if (bus.EN[0])
                r_presc <= r_presc + PW'(1);

            if (w_time_adj) begin
                if (w_sel == SEL_TIME_H)
                    r_h <= w_h_adj;
                else
                    r_m <= w_m_adj;
`ifdef ADJ_SEC_CLR_EN
                r_s     <= '0;
                r_presc <= '0;
`endif
            end else if (w_wrap) begin
                r_s <= w_s_tick;
                r_m <= w_m_tick;
                r_h <= w_h_tick;
            end

            if (w_sel == SEL_ALARM_H) begin
                r_ah    <= w_ah_adj;
                r_armed <= 1'b1;
            end else if (w_sel == SEL_ALARM_M) begin
                r_am    <= w_am_adj;
                r_armed <= 1'b1;
            end
        end
    end

    assign bus.time_h  = r_h;
    assign bus.time_m  = r_m;
    assign bus.time_s  = r_s;
    assign bus.alarm_h = r_ah;
    assign bus.alarm_m = r_am;
    assign bus.armed   = r_armed;
    assign bus.Z       = r_z;
    assign bus.tick    = r_tick;
endmodule

// File: doc/time_keeper.md
# time_keeper

Timekeeping datapath directly downstream of the mode controller FSM. Consumes the controller's `EN` field-select vector and `adjust` flag together with the debounced `up`/`down` pulses. Maintains the running 24-hour time (h:m:s) and the alarm setpoint (h:m), and produces the registered alarm-match flag `Z` that the controller uses to enter and leave its Alarm state. Also drives the display mux with the current hour/minute values.

## Interface
- `TICK_DIV`, 100_000_000: clock cycles per second tick (≥2).
- `clk` in 1: system clock; all logic on rising edge.
- `rst` in 1: synchronous reset, active-low.
- `EN` in 5: field select from the controller:
  - [4] time-hours adjust
  - [3] time-minutes adjust
  - [2] alarm-hours adjust
  - [1] alarm-minutes adjust
  - [0] timekeeping run
- `adjust` in 1: high while the controller is in an adjust state; gates `up`/`down`.
- `up` in 1: single-cycle increment pulse.
- `down` in 1: single-cycle decrement pulse.
- `time_h` out 5: current hour, 0–23.
- `time_m` out 6: current minute, 0–59.
- `time_s` out 6: current second, 0–59.
- `alarm_h` out 5: alarm hour, 0–23.
- `alarm_m` out 6: alarm minute, 0–59.
- `armed` out 1: alarm has been set at least once since reset.
- `Z` out 1: registered alarm match.
- `tick` out 1: one-cycle pulse per second while running.

## Operation
- **Prescaler.**
  - Counts 0..TICK_DIV-1 only while `EN[0]`=1 and holds its value while `EN[0]`=0.
  - `tick` pulses for one cycle when the prescaler wraps from TICK_DIV-1 to 0.
- **Time chain on `tick`.**
  - s increments; 59→0 carries to m.
  - m increments; 59→0 carries to h.
  - h increments; 23→0 wraps with no further carry.
- **Adjust.** Applies only when `adjust`=1 and exactly one of `up`/`down` is high.
  - Target field is the highest set bit of `EN[4:1]`, priority 4>3>2>1.
  - `up` adds 1 modulo the field range (hours 24, minutes 60). `down` subtracts 1 modulo the field range.
  - Adjusting a field never carries into a neighbouring field: 59→0 minutes leaves hours unchanged.
  - `up`&`down` both high: no change.
  - `adjust`=0: `up`/`down` ignored.
- **Arming.** `armed` sets on any applied alarm-field adjust (`EN[2]` or `EN[1]` target). It clears only on reset.
- **Match.** `Z` is registered as `armed` & (time_h==alarm_h) & (time_m==alarm_m), so it stays high for the whole matching minute.
- **Collisions.**
  - If a time-field adjust (`EN[4]`/`EN[3]`) coincides with `tick`, the adjust is applied and the tick is discarded for all time registers.
  - Alarm-field adjusts coincide freely with ticks; the time chain advances normally.

## Timing
- **Reset** (`rst`=0 at a clock edge) forces:
  - time 00:00:00 and alarm 00:00
  - prescaler 0
  - `armed`=0, `Z`=0, `tick`=0
- Reset has priority over all other inputs, including mid-tick and mid-adjust.
- **Latency.**
  - An adjust pulse at edge N updates the field outputs at edge N.
  - `Z` reflects the new values at edge N+1.
  - `tick` is registered and coincides with the time update.
- **Rates.**
  - An `up`/`down` pulse held high for k cycles yields k steps. The upstream debouncer guarantees single-cycle pulses.
  - `tick` period is exactly TICK_DIV cycles while `EN[0]` stays high.

## Configuration
- **`ADJ_SEC_CLR_EN` defined:** any applied time-hours or time-minutes adjust also clears `time_s` and the prescaler to 0 in the same cycle.
- **`ADJ_SEC_CLR_EN` undefined:** seconds and prescaler are unaffected by adjusts.

## Test plan
- **Reset.** Reset, then release with EN=00001 and TICK_DIV=4. Required: `tick` at cycles 4, 8, 12…; `time_s` 0→1→2; `Z`=0; `armed`=0.
- **Rollover.** Preload 23:59:59 via adjusts, then run. Required: next `tick` gives 00:00:00, with `Z` unchanged because `armed`=0.
- **Adjust wrap.**
  - EN=10000, `adjust`=1, `down` pulse at hour 0 → hour 23.
  - EN=01000, `up` at minute 59 → 0, with hours unchanged.
  - `up`&`down` together → no change.
- **Alarm match.**
  - EN=00101, `up` ×7 → alarm_h=7 and `armed`=1.
  - Set time to 06:59:58, then run with EN=00001. Required: `Z` rises one cycle after the 07:00:00 tick; it falls one cycle after the 07:01:00 tick.
- **Collision.** An EN=10000 `up` coinciding with a forced tick condition. Required: hour+1 and seconds not advanced. Repeat with EN=00101: alarm_h+1 and seconds advanced.
- **Macro.** With `ADJ_SEC_CLR_EN`, at time 10:20:33 an EN=01000 `up` gives 10:21:00 and the next tick arrives TICK_DIV cycles later. Without the macro the same stimulus gives 10:21:33.
